// File: rtl/npc_wb_pkg.sv
// Shared constants for the register-file writeback path: requester indices and
// the round-robin pointer sizing helper.
package npc_wb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 3;
  localparam int unsigned PTR_WIDTH       = $clog2(NUM_REQ_DEFAULT);

  localparam int unsigned WB_SRC_ALU = 0;
  localparam int unsigned WB_SRC_LSU = 1;
  localparam int unsigned WB_SRC_CSR = 2;

  // Keeps the pointer at least one bit wide for degenerate requester counts.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the
// pointer wins, wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       sum;
  logic                 found;

  always_comb begin
    // Rotate so bit j of rot is requester (ptr + j) mod NUM_REQ.
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = PTR_W'(i);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ)) begin
      sum = sum - (PTR_W+1)'(NUM_REQ);
    end
    idx_o = found ? sum[PTR_W-1:0] : '0;
    gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port,
// with a one-cycle output stage and read-side forwarding of the pending write.
module regfile_wb_arbiter
  import npc_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat_i,
  output logic [ADDR_WIDTH-1:0]         wb_rd_o,
  output logic [DATA_WIDTH-1:0]         wb_dat_o,
  output logic                          wb_en_o,
  input  logic [ADDR_WIDTH-1:0]         rs1_i,
  input  logic [ADDR_WIDTH-1:0]         rs2_i,
  input  logic [DATA_WIDTH-1:0]         rs1_rf_i,
  input  logic [DATA_WIDTH-1:0]         rs2_rf_i,
  output logic [DATA_WIDTH-1:0]         rs1_val_o,
  output logic [DATA_WIDTH-1:0]         rs2_val_o,
  output logic [2:0]                    grant_idx_o
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [2:0]            grant_idx_q, grant_idx_d;
  logic                  wb_en_q, wb_en_d;
  logic [ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [PtrW-1:0]       arb_idx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_dat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Grants are suppressed while reset is held so nothing is handshaken.
  assign req_ready_o = rst_n ? arb_gnt : '0;
  assign accept      = |(req_valid_i & req_ready_o);

  assign sel_rd  = req_rd_i[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_dat = req_dat_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    wb_en_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_dat_d    = wb_dat_q;
    if (accept) begin
      ptr_d       = (arb_idx == PtrW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      grant_idx_d = 3'(arb_idx);
      wb_en_d     = (sel_rd != '0);
      wb_rd_d     = sel_rd;
      wb_dat_d    = sel_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      grant_idx_q <= '0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_dat_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_dat_q    <= wb_dat_d;
    end
  end

  assign wb_en_o     = wb_en_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_dat_o    = wb_dat_q;
  assign grant_idx_o = grant_idx_q;

  // The held write lands at the next edge; decode must see it now.
  assign rs1_val_o = (wb_en_q && (rs1_i == wb_rd_q) && (rs1_i != '0)) ? wb_dat_q : rs1_rf_i;
  assign rs2_val_o = (wb_en_q && (rs2_i == wb_rd_q) && (rs2_i != '0)) ? wb_dat_q : rs2_rf_i;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: behavioural model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*AW-1:0] rd;
  logic [N*DW-1:0] dat;
  logic [AW-1:0]   wb_rd, rs1, rs2;
  logic [DW-1:0]   wb_dat, rs1_rf, rs2_rf, rs1_val, rs2_val;
  logic            wb_en;
  logic [2:0]      gidx;

  int checks = 0;
  int failures = 0;

  // Model state
  int            m_ptr, m_gidx, m_pick;
  bit            m_en;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_dat;

  // Register file emulation fed by the write port
  logic [DW-1:0] rf [32];
  int            wr4 = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .req_rd_i    (rd),
    .req_dat_i   (dat),
    .wb_rd_o     (wb_rd),
    .wb_dat_o    (wb_dat),
    .wb_en_o     (wb_en),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .rs1_rf_i    (rs1_rf),
    .rs2_rf_i    (rs2_rf),
    .rs1_val_o   (rs1_val),
    .rs2_val_o   (rs2_val),
    .grant_idx_o (gidx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester scanning upward from p, wrapping; -1 if none.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] rs, input logic [DW-1:0] rfv);
    if (m_en && rs == m_rd && rs != 0) return m_dat;
    return rfv;
  endfunction

  assign m_pick = model_pick(valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr  <= 0;
      m_gidx <= 0;
      m_en   <= 1'b0;
      m_rd   <= '0;
      m_dat  <= '0;
    end else if (m_pick >= 0) begin
      m_ptr  <= (m_pick + 1) % N;
      m_gidx <= m_pick;
      m_rd   <= AW'(rd >> (m_pick * AW));
      m_dat  <= DW'(dat >> (m_pick * DW));
      m_en   <= (AW'(rd >> (m_pick * AW)) != 0);
    end else begin
      m_en <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(ready), (rst_n && m_pick >= 0) ? (32'd1 << m_pick) : 32'd0);
    chk("wb_en", 32'(wb_en), 32'(m_en));
    chk("wb_rd", 32'(wb_rd), 32'(m_rd));
    chk("wb_dat", wb_dat, m_dat);
    chk("grant_idx", 32'(gidx), 32'(m_gidx));
    chk("rs1_val", rs1_val, fwd(rs1, rs1_rf));
    chk("rs2_val", rs2_val, fwd(rs2, rs2_rf));
    if (rst_n && wb_en) begin
      rf[wb_rd] <= wb_dat;
      if (wb_rd == 5'd4) wr4 <= wr4 + 1;
    end
  end

  task automatic setreq(input logic [N-1:0] v,
                        input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] r2, input logic [DW-1:0] d2);
    valid = v;
    rd    = {r2, r1, r0};
    dat   = {d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rs1 = 5'd7; rs2 = 5'd3; rs1_rf = 32'hF1; rs2_rf = 32'hF2;
    setreq(3'b111, 5'd1, 32'hA, 5'd2, 32'hB, 5'd3, 32'hC);

    // Reset held with every requester valid
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_en", 32'(wb_en), 32'd0);
    chk("rst_gidx", 32'(gidx), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("first_grant", 32'(ready), 32'b001);

    // Strict rotation
    for (int c = 0; c < 6; c++) begin
      chk("rot_ready", 32'(ready), 32'd1 << (c % 3));
      tick();
      chk("rot_wb_rd", 32'(wb_rd), 32'((c % 3) + 1));
      chk("rot_wb_en", 32'(wb_en), 32'd1);
      chk("rot_gidx", 32'(gidx), 32'(c % 3));
    end
    setreq(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("idle_en", 32'(wb_en), 32'd0);
    chk("idle_hold_rd", 32'(wb_rd), 32'd3);
    chk("idle_hold_dat", wb_dat, 32'hC);

    // Skip and wrap: move pointer to 2, then only requester 1 valid
    setreq(3'b010, 5'd0, 32'h0, 5'd6, 32'h66, 5'd0, 32'h0);
    tick();
    setreq(3'b010, 5'd0, 32'h0, 5'd5, 32'h55, 5'd0, 32'h0);
    #1 chk("skip_ready", 32'(ready), 32'b010);
    tick();
    chk("skip_wb_rd", 32'(wb_rd), 32'd5);
    chk("skip_wb_dat", wb_dat, 32'h55);
    chk("skip_wb_en", 32'(wb_en), 32'd1);
    chk("skip_gidx", 32'(gidx), 32'd1);
    setreq(3'b111, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h99);
    #1 chk("ptr_is_2", 32'(ready), 32'b100);

    // x0 drop: pointer back to 0 first
    setreq(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h99);
    tick();
    setreq(3'b001, 5'd0, 32'hDEAD, 5'd0, 32'h0, 5'd0, 32'h0);
    #1 chk("x0_ready", 32'(ready), 32'b001);
    tick();
    chk("x0_no_en", 32'(wb_en), 32'd0);
    setreq(3'b111, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    #1 chk("x0_ptr_adv", 32'(ready), 32'b010);

    // Forwarding
    setreq(3'b010, 5'd0, 32'h0, 5'd7, 32'h1234, 5'd0, 32'h0);
    tick();
    setreq(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    rs1 = 5'd7; rs1_rf = 32'h0; rs2 = 5'd8; rs2_rf = 32'h99;
    #1 chk("fwd_rs1", rs1_val, 32'h1234);
    chk("fwd_rs2", rs2_val, 32'h99);
    rs1 = 5'd0; rs1_rf = 32'h77;
    #1 chk("fwd_rs1_x0", rs1_val, 32'h77);

    // Same rd back to back: grant order 2 then 0, last write wins
    setreq(3'b101, 5'd3, 32'h222, 5'd0, 32'h0, 5'd3, 32'h111);
    tick();
    chk("same_rd_first", wb_dat, 32'h111);
    tick();
    chk("same_rd_second", wb_dat, 32'h222);
    setreq(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("last_wins", rf[3], 32'h222);

    // Reset pulse while a write of rd 4 is held
    setreq(3'b111, 5'd4, 32'h4444, 5'd4, 32'h4444, 5'd4, 32'h4444);
    tick();
    chk("pre_rst_en", 32'(wb_en), 32'd1);
    setreq(3'b111, 5'd1, 32'h10, 5'd2, 32'h20, 5'd3, 32'h30);
    rst_n = 1'b0;
    #1 chk("async_en", 32'(wb_en), 32'd0);
    chk("async_rd", 32'(wb_rd), 32'd0);
    chk("async_dat", wb_dat, 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    #1 rst_n = 1'b1;
    #1 chk("restart_ready", 32'(ready), 32'b001);
    tick();
    chk("restart_gidx", 32'(gidx), 32'd0);
    chk("restart_rd", 32'(wb_rd), 32'd1);
    setreq(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    tick();
    chk("no_rd4_write", 32'(wr4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
